// File: rtl/gcd_result_buffer.sv
// rtl/gcd_result_buffer.sv - FWFT result buffer capturing GCD core completions on ready rising edges
module gcd_result_buffer #(
    parameter int word  = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [word-1:0]            gcd_data_i,
    input  logic                       gcd_ready_i,
    output logic [word-1:0]            m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  ready_q, ready_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [word-1:0]       mem_q [DEPTH];
    logic [word-1:0]       mem_d [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic not_empty;
    logic wr_en;
    logic drop;

    // Event decode: a push is a rising edge of the upstream level-type ready flag
    always_comb begin
        push      = gcd_ready_i & ~ready_q;
        full      = (count_q == CNT_W'(DEPTH));
        not_empty = (count_q != '0);
        pop       = not_empty & m_ready_i;
        // A full buffer still accepts a push when the head leaves in the same cycle
        wr_en     = push & (~full | pop);
        drop      = push & full & ~pop;
    end

    // Next-state for pointers, occupancy, edge detector and sticky overflow
    always_comb begin
        ready_d    = gcd_ready_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state for storage: only the slot under wr_ptr changes on an accepted push
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = gcd_data_i;
        end
    end

    // Control state register; ready_q resets high so a ready already high at release is not a push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage register; contents are never exposed while empty, so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs: head entry falls through, zeros while empty
    always_comb begin
        m_valid_o  = not_empty;
        m_data_o   = not_empty ? mem_q[rd_ptr_q] : '0;
        count_o    = count_q;
        full_o     = full;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_gcd_result_buffer.sv
// tb/tb_gcd_result_buffer.sv - scoreboard bench for gcd_result_buffer
module tb_gcd_result_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [W-1:0]     gcd_data_i;
    logic             gcd_ready_i;
    logic [W-1:0]     m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [2:0]       count_o;
    logic             full_o;
    logic             overflow_o;

    gcd_result_buffer #(.word(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .gcd_data_i  (gcd_data_i),
        .gcd_ready_i (gcd_ready_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb [$];
    int           exp_count;
    logic         exp_ovf;
    logic         prev_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_count  = 0;
        exp_ovf    = 1'b0;
        prev_ready = 1'b1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(count_o), 32'(exp_count));
        chk({tag, ".valid"}, 32'(m_valid_o), 32'(exp_count != 0));
        chk({tag, ".full"}, 32'(full_o), 32'(exp_count == DEPTH));
        chk({tag, ".ovf"}, 32'(overflow_o), 32'(exp_ovf));
        if (exp_count == 0) begin
            chk({tag, ".zero_data"}, 32'(m_data_o), 32'h0);
        end
    endtask

    // Called at a falling edge with inputs already driven; predicts the next rising edge
    task automatic tick(input string tag);
        logic        do_push;
        logic        do_pop;
        logic [W-1:0] head;
        check_status(tag);
        do_push = gcd_ready_i && !prev_ready;
        do_pop  = (exp_count != 0) && m_ready_i;
        if (do_pop) begin
            head = sb.pop_front();
            chk({tag, ".data"}, 32'(m_data_o), 32'(head));
            exp_count--;
        end
        if (do_push) begin
            if (exp_count < DEPTH) begin
                sb.push_back(gcd_data_i);
                exp_count++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        prev_ready = gcd_ready_i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [W-1:0] d, input string tag);
        gcd_data_i  = d;
        gcd_ready_i = 1'b1;
        tick(tag);
        gcd_ready_i = 1'b0;
        gcd_data_i  = 8'hEE;
        tick(tag);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 20;
        m_ready_i = 1'b1;
        while (exp_count != 0 && budget > 0) begin
            tick(tag);
            budget--;
        end
        chk({tag, ".drain_budget"}, 32'(exp_count), 32'h0);
        m_ready_i = 1'b0;
        tick({tag, ".after"});
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst         = 1'b1;
        gcd_data_i  = '0;
        gcd_ready_i = 1'b0;
        m_ready_i   = 1'b0;
        model_reset();
        #2;
        check_status("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single result, held ready produces a single push
        tick("idle");
        gcd_data_i  = 8'h06;
        gcd_ready_i = 1'b1;
        tick("single.push");
        chk("single.head", 32'(m_data_o), 32'h06);
        repeat (5) tick("single.hold");
        chk("single.count_held", 32'(count_o), 32'h1);
        gcd_ready_i = 1'b0;
        drain("single.drain");

        // Fill then drain in order
        pulse(8'h01, "fill");
        pulse(8'h02, "fill");
        pulse(8'h03, "fill");
        pulse(8'h04, "fill");
        chk("fill.full", 32'(full_o), 32'h1);
        drain("fill.drain");
        chk("fill.end_valid", 32'(m_valid_o), 32'h0);
        chk("fill.end_data", 32'(m_data_o), 32'h0);

        // Overflow: fifth result dropped, flag sticky
        pulse(8'h01, "ovf.fill");
        pulse(8'h02, "ovf.fill");
        pulse(8'h03, "ovf.fill");
        pulse(8'h04, "ovf.fill");
        pulse(8'h05, "ovf.fifth");
        chk("ovf.flag", 32'(overflow_o), 32'h1);
        drain("ovf.drain");
        chk("ovf.sticky", 32'(overflow_o), 32'h1);

        // Push and pop together at full
        sync_reset();
        tick("simul.post_reset");
        pulse(8'h01, "simul.fill");
        pulse(8'h02, "simul.fill");
        pulse(8'h03, "simul.fill");
        pulse(8'h04, "simul.fill");
        gcd_data_i  = 8'h09;
        gcd_ready_i = 1'b1;
        m_ready_i   = 1'b1;
        tick("simul.both");
        gcd_ready_i = 1'b0;
        m_ready_i   = 1'b0;
        tick("simul.settle");
        chk("simul.count", 32'(count_o), 32'h4);
        chk("simul.no_ovf", 32'(overflow_o), 32'h0);
        drain("simul.drain");

        // Wrap-around with occupancy alternating between 1 and 2
        pulse(8'h10, "wrap.prime");
        for (int i = 1; i < 10; i++) begin
            gcd_data_i  = 8'(8'h10 + i);
            gcd_ready_i = 1'b1;
            m_ready_i   = 1'b0;
            tick("wrap.push");
            gcd_ready_i = 1'b0;
            m_ready_i   = 1'b1;
            tick("wrap.pop");
        end
        m_ready_i = 1'b0;
        drain("wrap.drain");
        chk("wrap.sb_empty", 32'(sb.size()), 32'h0);

        // Asynchronous reset mid-operation with ready held high across release
        pulse(8'h21, "arst.fill");
        pulse(8'h22, "arst.fill");
        gcd_data_i  = 8'h23;
        gcd_ready_i = 1'b1;
        tick("arst.fill3");
        chk("arst.count3", 32'(count_o), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.count", 32'(count_o), 32'h0);
        chk("arst.valid", 32'(m_valid_o), 32'h0);
        chk("arst.ovf", 32'(overflow_o), 32'h0);
        chk("arst.data", 32'(m_data_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        gcd_data_i = 8'h31;
        repeat (3) tick("arst.held");
        chk("arst.no_push", 32'(count_o), 32'h0);
        gcd_ready_i = 1'b0;
        tick("arst.low");
        gcd_ready_i = 1'b1;
        tick("arst.rise");
        chk("arst.head", 32'(m_data_o), 32'h31);
        gcd_ready_i = 1'b0;
        drain("arst.drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gcd_result_buffer.md
GCD_RESULT_BUFFER -- requirements
Module: gcd_result_buffer

Interface
REQ-001 Parameter: word, default 8, width of GCD result and of each buffer entry.
REQ-002 Parameter: DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: gcd_data_i  input  word  result from the upstream GCD core (its data_o).
REQ-006 Port: gcd_ready_i  input  1  level-type completion flag from the upstream GCD core (its ready).
REQ-007 Port: m_data_o  output  word  head-of-buffer result (first-word-fall-through).
REQ-008 Port: m_valid_o  output  1  head entry valid.
REQ-009 Port: m_ready_i  input  1  consumer accepts head entry.
REQ-010 Port: count_o  output  clog2(DEPTH)+1  number of stored entries.
REQ-011 Port: full_o  output  1  count_o == DEPTH.
REQ-012 Port: overflow_o  output  1  sticky flag: a result was dropped.

Function
REQ-013 Capture event ("push") SHALL be a 0->1 transition of gcd_ready_i, detected against a registered copy ready_q of gcd_ready_i from the previous cycle.
REQ-014 On push, the value of gcd_data_i sampled in the same cycle the rising edge is seen SHALL be written at wr_ptr.
REQ-015 gcd_ready_i held high for multiple cycles SHALL produce exactly one push; a further push requires gcd_ready_i to drop and rise again.
REQ-016 "Pop" SHALL occur in a cycle where m_valid_o=1 and m_ready_i=1; rd_ptr advances by one.
REQ-017 m_valid_o SHALL equal (count_o != 0); m_data_o SHALL equal mem[rd_ptr] when m_valid_o=1 and SHALL be all-zeros when m_valid_o=0.
REQ-018 Latency: a result pushed in cycle N SHALL appear on m_data_o with m_valid_o=1 in cycle N+1 when the buffer was empty.
REQ-019 Pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without a gap.
REQ-020 Push and pop in the same cycle with 0 < count < DEPTH: both occur, count unchanged.
REQ-021 Push and pop in the same cycle when full: both occur, count stays DEPTH, overflow_o unchanged.
REQ-022 Push when full without pop: data SHALL be discarded, memory and wr_ptr unchanged, overflow_o set to 1.
REQ-023 Pop when empty is impossible (m_valid_o=0); m_ready_i SHALL be ignored while empty.
REQ-024 Push when empty with m_ready_i=1: no pop that cycle (m_valid_o was 0); count becomes 1.
REQ-025 overflow_o SHALL remain 1 until reset.
REQ-026 Results SHALL be delivered in capture order; no reordering or duplication.

Reset
REQ-027 While rst=1, asynchronously: wr_ptr=0, rd_ptr=0, count_o=0, full_o=0, overflow_o=0, m_valid_o=0, m_data_o=0, ready_q=1.
REQ-028 ready_q resetting to 1 SHALL suppress a push when gcd_ready_i is already high on the first cycle after reset release.
REQ-029 Memory contents need not be reset; they SHALL never be visible on m_data_o while m_valid_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; pushes after release start at entry 0.

Verification
REQ-031 Single result: gcd_ready_i 0->1 with gcd_data_i=8'h06, m_ready_i=0 -> next cycle m_valid_o=1, m_data_o=8'h06, count_o=1; gcd_ready_i held high 5 cycles -> count_o remains 1.
REQ-032 Fill/drain: 4 pulses with 8'h01,8'h02,8'h03,8'h04, m_ready_i=0 -> full_o=1, count_o=4; then m_ready_i=1 -> outputs 01,02,03,04 on consecutive cycles, then m_valid_o=0, m_data_o=0.
REQ-033 Overflow: full with 01..04, fifth pulse 8'h05, m_ready_i=0 -> overflow_o=1, count_o=4, drained sequence 01,02,03,04 (05 absent); overflow_o stays 1.
REQ-034 Simultaneous at full: full, m_ready_i=1 in the same cycle as pulse 8'h09 -> count_o stays 4, overflow_o=0, 8'h09 emerges last.
REQ-035 Wrap-around: 10 push/pop pairs with values 8'h10..8'h19, interleaved at count 1-2 -> output order 10..19 exact, no loss.
REQ-036 Reset mid-operation: count_o=3, assert rst asynchronously between clock edges -> count_o=0, m_valid_o=0, overflow_o=0 immediately; gcd_ready_i high at release -> no push until it falls and rises again.
